// File: rtl/banked_mem.sv
// banked_mem: BANKS-way banked single-port RAM behind a valid/ready port, with a clear engine.
// Define BANKED_MEM_PARITY_EN to add per-word even parity with inj_par / rsp_err ports.
`timescale 1ns/1ps
module banked_mem #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int BANKS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
`ifdef BANKED_MEM_PARITY_EN
    input  logic          inj_par,
    output logic          rsp_err,
`endif
    input  logic          clr,
    output logic          busy
);
    // state    | meaning
    // ST_CLEAR | zeroing index r_clr_idx in every bank, port busy
    // ST_IDLE  | accepting requests, clr pulse starts a new clear

    localparam int BSW    = $clog2(BANKS);
    localparam int BAW    = AW - BSW;
    localparam int BDEPTH = 1 << BAW;
`ifdef BANKED_MEM_PARITY_EN
    localparam int WW = DW + 1;
`else
    localparam int WW = DW;
`endif

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BAW-1:0]  r_clr_idx;
    logic [BAW-1:0]  w_clr_idx_nxt;
    logic            w_clr_we;
    logic            w_accept;
    logic            w_wr;
    logic            w_rd;
    logic [BSW-1:0]  w_bank;
    logic [BAW-1:0]  w_idx;
    logic [WW-1:0]   w_wword;
    logic [WW-1:0]   w_rword;
    logic [WW-1:0]   w_bank_rd [BANKS];
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_data;

    assign w_accept = req_valid & req_ready;
    assign w_wr     = w_accept & req_we;
    assign w_rd     = w_accept & ~req_we;
    assign w_bank   = req_addr[AW-1:BAW];
    assign w_idx    = req_addr[BAW-1:0];

`ifdef BANKED_MEM_PARITY_EN
    assign w_wword = {(^req_data) ^ inj_par, req_data};
`else
    assign w_wword = req_data;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        busy          = 1'b0;
        req_ready     = 1'b0;
        w_clr_we      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                busy          = 1'b1;
                w_clr_we      = 1'b1;
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (&r_clr_idx) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_idx_nxt = '0;
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                if (clr) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    // Storage has no reset; only the clear engine zeroes it.
    for (genvar gb = 0; gb < BANKS; gb++) begin : g_bank
        logic [WW-1:0] r_bank_mem [BDEPTH];

        always_ff @(posedge clk) begin
            if (w_clr_we) begin
                r_bank_mem[r_clr_idx] <= '0;
            end else if (w_wr && (w_bank == BSW'(gb))) begin
                r_bank_mem[w_idx] <= w_wword;
            end
        end

        assign w_bank_rd[gb] = r_bank_mem[w_idx];
    end

    assign w_rword = w_bank_rd[w_bank];

`ifdef BANKED_MEM_PARITY_EN
    logic r_rsp_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_clr_idx   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
`ifdef BANKED_MEM_PARITY_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_clr_idx   <= w_clr_idx_nxt;
            r_rsp_valid <= w_rd;
            if (w_rd) begin
                r_rsp_data <= w_rword[DW-1:0];
            end
`ifdef BANKED_MEM_PARITY_EN
            r_rsp_err   <= w_rd & (^w_rword);
`endif
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
`ifdef BANKED_MEM_PARITY_EN
    assign rsp_err   = r_rsp_err;
`endif

endmodule
